// File: rtl/sum_result_fifo.sv
// sum_result_fifo: FIFO for {carry, sum} results from the upstream 4-bit adder.
// Latency: one cycle from push to out_valid (no empty bypass); the head shows through directly.
// Backpressure: in_ready = !full and ignores out_ready. Optional stats counters are enabled by SUM_RESULT_FIFO_STATS_EN.
module sum_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic                     in_carry,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef SUM_RESULT_FIFO_STATS_EN
  ,
  output logic [7:0]               carry_cnt,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Each entry is the raw {carry, sum} pair; nothing is computed on it.
  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [WIDTH:0]  head;
  logic            push;
  logic            pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  // Head entry is masked to zero while empty so stale storage never leaks out.
  assign head      = mem[rd_ptr];
  assign out_sum   = empty ? '0 : head[WIDTH-1:0];
  assign out_carry = empty ? 1'b0 : head[WIDTH];

  // Storage write; contents are not cleared by reset since they are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= {in_carry, in_sum};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

`ifdef SUM_RESULT_FIFO_STATS_EN
  // Saturating counters: carries among accepted pushes, and cycles offering data while full.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push && in_carry && carry_cnt != 8'hFF) carry_cnt <= carry_cnt + 8'd1;
      if (in_valid && full && drop_cnt != 8'hFF)  drop_cnt  <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sum_result_fifo.sv
// Testbench for sum_result_fifo: table-driven directed vectors plus a queue scoreboard.
// The scoreboard is updated on the falling edge from the applied inputs and its own occupancy.
module tb_sum_result_fifo;
  localparam int DEPTH = 4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_sum;
  logic             in_carry;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic [2:0]       count;
  logic             full;
  logic             empty;
`ifdef SUM_RESULT_FIFO_STATS_EN
  logic [7:0]       carry_cnt;
  logic [7:0]       drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH:0] sb [$];

  sum_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sum(in_sum), .in_carry(in_carry), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .count(count), .full(full), .empty(empty)
`ifdef SUM_RESULT_FIFO_STATS_EN
    , .carry_cnt(carry_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: check outputs against the model, then apply this cycle's push/pop to it.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      automatic bit pop_ok  = out_ready && sb.size() > 0;
      automatic bit push_ok = in_valid && sb.size() < DEPTH;
      chk("sb_count", int'(count), sb.size());
      chk("sb_out_valid", int'(out_valid), int'(sb.size() != 0));
      chk("sb_in_ready", int'(in_ready), int'(sb.size() < DEPTH));
      if (sb.size() == 0) chk("sb_idle_out", int'({out_carry, out_sum}), 0);
      else                chk("sb_head", int'({out_carry, out_sum}), int'(sb[0]));
      if (pop_ok)  void'(sb.pop_front());
      if (push_ok) sb.push_back({in_carry, in_sum});
    end
  end

  typedef struct {
    logic       iv;
    logic [3:0] s;
    logic       c;
    logic       ordy;
    int         cnt;
    logic       fl;
    logic       ov;
    logic [3:0] osum;
    logic       ocar;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Fill to full, attempt an overflow push, then drain in order and pop once while empty.
    tbl[0] = '{1'b1, 4'b0011, 1'b0, 1'b0, 1, 1'b0, 1'b1, 4'b0011, 1'b0};
    tbl[1] = '{1'b1, 4'b1011, 1'b0, 1'b0, 2, 1'b0, 1'b1, 4'b0011, 1'b0};
    tbl[2] = '{1'b1, 4'b0000, 1'b1, 1'b0, 3, 1'b0, 1'b1, 4'b0011, 1'b0};
    tbl[3] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4, 1'b1, 1'b1, 4'b0011, 1'b0};
    tbl[4] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4, 1'b1, 1'b1, 4'b0011, 1'b0};
    tbl[5] = '{1'b0, 4'b0000, 1'b0, 1'b1, 3, 1'b0, 1'b1, 4'b1011, 1'b0};
    tbl[6] = '{1'b0, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 1'b1, 4'b0000, 1'b1};
    tbl[7] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1, 1'b0, 1'b1, 4'b1111, 1'b0};
    tbl[8] = '{1'b0, 4'b0000, 1'b0, 1'b1, 0, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[9] = '{1'b0, 4'b0000, 1'b0, 1'b1, 0, 1'b0, 1'b0, 4'b0000, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_full", int'(full), 0);

    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].iv; in_sum = tbl[i].s; in_carry = tbl[i].c; out_ready = tbl[i].ordy;
      step();
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].fl));
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(!tbl[i].fl));
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_sum", i), int'(out_sum), int'(tbl[i].osum));
      chk($sformatf("tbl%0d_out_carry", i), int'(out_carry), int'(tbl[i].ocar));
`ifdef SUM_RESULT_FIFO_STATS_EN
      if (i == 4) begin
        chk("stats_drop_cnt", int'(drop_cnt), 1);
        chk("stats_carry_cnt", int'(carry_cnt), 1);
      end
`endif
    end

    // Push into an empty FIFO: not visible in the push cycle, visible the next.
    in_valid = 1'b1; in_sum = 4'b0000; in_carry = 1'b1; out_ready = 1'b0;
    #1;
    chk("nobypass_out_valid", int'(out_valid), 0);
    step();
    chk("push1_out_valid", int'(out_valid), 1);
    chk("push1_out_carry", int'(out_carry), 1);
    chk("push1_out_sum", int'(out_sum), 0);

    // Hold occupancy at 2 with simultaneous push and pop; pointers wrap several times.
    in_valid = 1'b1; in_sum = 4'h5; in_carry = 1'b0; out_ready = 1'b0;
    step();
    chk("hold_count_init", int'(count), 2);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_sum = 4'(k + 6); in_carry = k[0]; out_ready = 1'b1;
      step();
      chk($sformatf("hold%0d_count", k), int'(count), 2);
    end

    // Reset while pushing at count 3: the pushed entry must be discarded.
    in_valid = 1'b1; in_sum = 4'h3; in_carry = 1'b1; out_ready = 1'b0;
    step();
    chk("prerst_count", int'(count), 3);
    reset = 1'b1; in_sum = 4'h9;
    step();
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    chk("postrst_count", int'(count), 0);
    chk("postrst_empty", int'(empty), 1);

    // Random traffic checked by the scoreboard, then drain.
    repeat (300) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sum    = 4'($urandom_range(0, 15));
      in_carry  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("drain_empty", int'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sum_result_fifo.md
SUM_RESULT_FIFO -- requirements
Module: sum_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; power of two, 2..16.
REQ-002 SHALL have parameter WIDTH, default 4, sum width in bits, matching the upstream 4-bit adder.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers a {carry_out, sum} result.
REQ-006 SHALL have port in_sum  input  WIDTH  adder sum.
REQ-007 SHALL have port in_carry  input  1  adder carry_out.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  downstream consumes head entry.
REQ-011 SHALL have port out_sum  output  WIDTH  head entry sum.
REQ-012 SHALL have port out_carry  output  1  head entry carry.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-014 SHALL have ports full and empty  output  1 each  occupancy flags.

Function
REQ-015 Push SHALL occur on a rising edge when in_valid && in_ready; pop when out_valid && out_ready.
REQ-016 in_ready SHALL equal !full and SHALL NOT depend on out_ready (no pass-through when full).
REQ-017 out_valid SHALL equal !empty; there SHALL be no empty-bypass, so an entry pushed in cycle N first appears on the outputs in cycle N+1.
REQ-018 out_sum/out_carry SHALL show the oldest entry (first-word-fall-through) and SHALL be 0 while empty.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and both SHALL take effect.
REQ-021 count SHALL increment on push-only, decrement on pop-only; full = (count==DEPTH), empty = (count==0).
REQ-022 in_valid while full SHALL be ignored: no state change, entry not stored.
REQ-023 out_ready while empty SHALL be ignored.
REQ-024 Stored data SHALL be (WIDTH+1) bits {carry, sum}, with no arithmetic applied.

Reset
REQ-025 With reset high at a rising edge, pointers and count SHALL become 0, empty=1, full=0, in_ready=1, out_valid=0, out_sum=0, out_carry=0.
REQ-026 Reset SHALL override any push or pop in the same cycle; in-flight entries SHALL be discarded.
REQ-027 Storage array contents need not be cleared; they SHALL never be visible while empty.

Configuration
REQ-028 With macro SUM_RESULT_FIFO_STATS_EN defined, outputs carry_cnt[7:0] and drop_cnt[7:0] SHALL exist.
REQ-029 carry_cnt SHALL count accepted pushes with in_carry=1; drop_cnt SHALL count cycles with in_valid && full. Both SHALL saturate at 255 and clear on reset.
REQ-030 Without the macro, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Reset then idle -> empty=1, count=0, in_ready=1, out_valid=0, out_sum=0.
REQ-032 Push {0,0011},{0,1011},{1,0000},{0,1111} with out_ready=0 -> full=1, count=4, in_ready=0; then drain -> outputs appear in the same order.
REQ-033 Push a 5th entry {1,1111} while full -> ignored, count stays 4, and with stats drop_cnt=1.
REQ-034 Hold count=2, then in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, data in order, pointers wrap correctly.
REQ-035 Push {1,0000} at cycle N into an empty FIFO -> out_valid=0 at N, and out_valid=1 with out_carry=1, out_sum=0000 at N+1.
REQ-036 Assert reset with count=3 while pushing -> next cycle count=0, empty=1, and the pushed entry is not stored.
